serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; the legal range SHALL be 2..32.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  operand set presented.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 A  input  WIDTH  addend A.
REQ-007 B  input  WIDTH  addend B.
REQ-008 cin  input  1  carry-in for bit 0.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 sum  output  WIDTH  result A+B+cin mod 2^WIDTH.
REQ-012 cout  output  1  carry-out of bit WIDTH-1.

Function
REQ-013 The block SHALL add bit-serially, LSB first, using exactly one 1-bit full-adder stage (sum = a^b^c, carry = ab|ac|bc) plus a registered carry.
REQ-014 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-015 IDLE: in_ready=1 and out_valid=0.
REQ-016 An accept edge is a rising edge with in_valid=1 and in_ready=1.
REQ-017 On an accept edge the block SHALL:
  - capture A and B into shift registers,
  - capture cin into the carry register,
  - clear the bit counter to 0,
  - go to BUSY.
REQ-018 BUSY: in_ready=0 and out_valid=0; in_valid, A, B and cin SHALL be ignored.
REQ-019 On each BUSY edge the block SHALL:
  - add the LSBs of the A and B shift registers and the carry register,
  - shift the sum bit into the MSB of the result shift register,
  - shift the operand registers right by 1,
  - load the carry register with the carry-out,
  - increment the counter.
REQ-020 On the BUSY edge where the counter equals WIDTH-1, the block SHALL go to DONE.
REQ-021 Latency: out_valid SHALL first be 1 exactly WIDTH rising edges after the accept edge.
REQ-022 DONE: out_valid=1, in_ready=0, sum = result register, cout = carry register.
REQ-023 sum and cout SHALL be stable for the entire DONE interval.
REQ-024 If out_ready=0 in DONE, the block SHALL remain in DONE and hold sum and cout.
REQ-025 On an edge with out_valid=1 and out_ready=1, the block SHALL go to IDLE.
REQ-026 in_ready SHALL be 1 on the cycle after the result handshake, so back-to-back throughput is one result per WIDTH+2 cycles.
REQ-027 out_ready while not in DONE SHALL have no effect.
REQ-028 sum and cout SHALL hold their last DONE values in IDLE and BUSY but are meaningful only while out_valid=1.
REQ-029 Arithmetic SHALL wrap modulo 2^WIDTH, with the overflow reported only on cout.
REQ-030 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never exceed WIDTH-1.

Reset
REQ-031 While rst=1, independent of clk, the block SHALL force:
  - state to IDLE,
  - counter, shift registers and carry register to 0,
  - in_ready=1, out_valid=0, sum=0, cout=0.
REQ-032 Reset asserted during BUSY or DONE SHALL abort the operation with no result emitted.
REQ-033 The first accept edge SHALL be the first rising edge with rst=0 and in_valid=1.

Verification
REQ-034 WIDTH=8, accept A=8'hFF, B=8'h01, cin=0 with out_ready=1 -> out_valid=1 exactly 8 edges after the accept edge, sum=8'h00, cout=1, then IDLE with in_ready=1 on the next cycle.
REQ-035 A=8'hA5, B=8'h5A, cin=1 -> sum=8'h00, cout=1; then A=8'h00, B=8'h00, cin=1 -> sum=8'h01, cout=0.
REQ-036 Backpressure: A=8'h3C, B=8'h0F, cin=0 with out_ready=0 for 5 cycles in DONE -> out_valid stays 1 and sum=8'h4B, cout=0 are held; first out_ready=1 edge -> IDLE.
REQ-037 Operand changes with in_valid=1 during BUSY (A=8'h11, B=8'h22) -> ignored; result equals the originally accepted operands; in_ready stays 0 until DONE completes.
REQ-038 Assert rst mid-BUSY (after 3 bits) -> out_valid=0, sum=0, cout=0 immediately; a new operation after release produces the correct result with full latency.
REQ-039 Randomized: 1000 random A/B/cin sets with random out_ready stalls -> {cout,sum} SHALL equal A+B+cin for every result.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a registered carry, LSB first.
// Valid/ready on both sides; one result every WIDTH+2 cycles back to back.

// Single-bit full adder used as the only arithmetic stage.
module serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
        $error("serial_adder: WIDTH must be in 2..32");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] res_next;

    serial_adder_fa u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .c  (carry),
        .s  (fa_s),
        .co (fa_c)
    );

    // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    assign res_next = {fa_s, res_sh[WIDTH-1:1]};

    // Control FSM and datapath. sum/cout are separate registers so they keep
    // the previous result while the shift registers are reused in BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= A;
                        b_sh     <= B;
                        carry    <= cin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    res_sh <= res_next;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_c;
                    if (cnt == LAST) begin
                        // Counter wraps to 0 rather than passing WIDTH-1.
                        cnt       <= '0;
                        sum       <= res_next;
                        cout      <= fa_c;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8).
module tb_serial_adder;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int checks = 0;
    int passed = 0;
    logic [WIDTH:0] sb[$];
    time t_acc;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    // Present one operand set for a single edge; expected value goes to the scoreboard.
    task automatic accept_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        @(negedge clk);
        A = a; B = b; cin = c; in_valid = 1'b1;
        @(posedge clk);
        t_acc = $time;
        sb.push_back({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c});
        #1 in_valid = 1'b0;
    endtask

    // Count edges until out_valid is seen; -1 if the bound expires.
    task automatic wait_valid(output int n);
        n = 0;
        repeat (40) begin
            @(posedge clk); #1;
            n++;
            if (out_valid) return;
        end
        n = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; cin = 1'b0;
        #2;
        checks++;
        if ({in_ready, out_valid, cout, sum} !== {1'b1, 1'b0, 1'b0, 8'h00})
            $display("FAIL reset: rdy=%b vld=%b cout=%b sum=%h, want 1 0 0 00", in_ready, out_valid, cout, sum);
        else passed++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int n;
        logic [WIDTH:0] exp;
        logic [WIDTH-1:0] av [3] = '{8'hFF, 8'hA5, 8'h00};
        logic [WIDTH-1:0] bv [3] = '{8'h01, 8'h5A, 8'h00};
        logic             cv [3] = '{1'b0, 1'b1, 1'b1};
        logic [WIDTH:0]   prev;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) $display("FAIL basic_idle_ready: got %b want 1", in_ready);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            prev = {cout, sum};
            accept_op(av[i], bv[i], cv[i]);
            if (i > 0) begin
                @(posedge clk); #1;
                checks++;
                if ({cout, sum} !== prev || in_ready !== 1'b0)
                    $display("FAIL basic_hold_busy%0d: got %h rdy=%b want %h rdy=0", i, {cout, sum}, in_ready, prev);
                else passed++;
            end
            wait_valid(n);
            if (i > 0 && n >= 0) n = n + 1;
            checks++;
            if (n !== WIDTH) $display("FAIL basic_latency%0d: got %0d want %0d", i, n, WIDTH);
            else passed++;
            exp = sb.pop_front();
            checks++;
            if ({cout, sum} !== exp) $display("FAIL basic_result%0d: got %h want %h", i, {cout, sum}, exp);
            else passed++;
            @(posedge clk); #1;
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0)
                $display("FAIL basic_return_idle%0d: rdy=%b vld=%b want 1 0", i, in_ready, out_valid);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [WIDTH:0] exp;
        out_ready = 1'b0;
        accept_op(8'h3C, 8'h0F, 1'b0);
        wait_valid(n);
        checks++;
        if (n !== WIDTH) $display("FAIL bp_latency: got %0d want %0d", n, WIDTH);
        else passed++;
        repeat (5) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || {cout, sum} !== 9'h04B)
                $display("FAIL bp_hold: vld=%b res=%h want 1 04b", out_valid, {cout, sum});
            else passed++;
        end
        exp = sb.pop_front();
        checks++;
        if ({cout, sum} !== exp) $display("FAIL bp_result: got %h want %h", {cout, sum}, exp);
        else passed++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_release: vld=%b rdy=%b want 0 1", out_valid, in_ready);
        else passed++;
    endtask

    task automatic test_busy_ignore();
        int n;
        logic [WIDTH:0] exp;
        out_ready = 1'b1;
        accept_op(8'h12, 8'h34, 1'b0);
        in_valid = 1'b1; A = 8'h11; B = 8'h22; cin = 1'b1;
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (out_valid) break;
            checks++;
            if (in_ready !== 1'b0) $display("FAIL busy_ready: got %b want 0", in_ready);
            else passed++;
        end
        in_valid = 1'b0;
        checks++;
        if (n !== WIDTH) $display("FAIL busy_latency: got %0d want %0d", n, WIDTH);
        else passed++;
        exp = sb.pop_front();
        checks++;
        if ({cout, sum} !== exp) $display("FAIL busy_result: got %h want %h", {cout, sum}, exp);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_busy();
        int n;
        logic [WIDTH:0] exp;
        out_ready = 1'b1;
        accept_op(8'h55, 8'h66, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, cout, sum} !== {1'b1, 1'b0, 1'b0, 8'h00})
            $display("FAIL rst_busy: rdy=%b vld=%b cout=%b sum=%h want 1 0 0 00", in_ready, out_valid, cout, sum);
        else passed++;
        void'(sb.pop_back());
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        accept_op(8'h77, 8'h99, 1'b1);
        wait_valid(n);
        checks++;
        if (n !== WIDTH) $display("FAIL rst_recover_latency: got %0d want %0d", n, WIDTH);
        else passed++;
        exp = sb.pop_front();
        checks++;
        if ({cout, sum} !== exp) $display("FAIL rst_recover_result: got %h want %h", {cout, sum}, exp);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int n;
        time t0;
        logic [WIDTH:0] exp;
        out_ready = 1'b1;
        accept_op(8'h80, 8'h80, 1'b0);
        t0 = t_acc;
        wait_valid(n);
        exp = sb.pop_front();
        checks++;
        if ({cout, sum} !== exp) $display("FAIL b2b_result0: got %h want %h", {cout, sum}, exp);
        else passed++;
        @(posedge clk); #1;
        accept_op(8'h7F, 8'h01, 1'b1);
        checks++;
        if (t_acc - t0 !== 100) $display("FAIL b2b_spacing: got %0t want 100", t_acc - t0);
        else passed++;
        wait_valid(n);
        exp = sb.pop_front();
        checks++;
        if ({cout, sum} !== exp) $display("FAIL b2b_result1: got %h want %h", {cout, sum}, exp);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int n;
        int stall;
        logic [WIDTH:0] exp;
        for (int i = 0; i < 1000; i++) begin
            out_ready = 1'($urandom);
            accept_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            wait_valid(n);
            if (n < 0) begin
                checks++;
                $display("FAIL rand_timeout: op %0d no out_valid within 40 edges", i);
                void'(sb.pop_front());
                continue;
            end
            stall = $urandom_range(0, 3);
            out_ready = 1'b0;
            repeat (stall) begin @(posedge clk); #1; end
            exp = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || {cout, sum} !== exp)
                $display("FAIL rand_result: op %0d vld=%b got %h want %h", i, out_valid, {cout, sum}, exp);
            else passed++;
            out_ready = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_busy_ignore();
        test_reset_mid_busy();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
